id_ex_hazard_pipe: RTL and testbench
====================================

// Module: id_ex_hazard_pipe
// PURPOSE
//  Decode->Execute->Memory register pipeline carrying hazard metadata (rd, opcode, rs1/rs2, valid).
//  Drives the rd/opcode inputs of the forwarding unit and consumes its stall signal.
//  Also consumes the decode branch-taken flush: injects bubbles into EX and holds the front end.
//  Keeps stall/flush statistics and a stall watchdog.
// PARAMETERS
//  CNT_W      16  width of the saturating stall/flush event counters
//  MAX_STALL  8   consecutive stall cycles that raise o_stall_err (range 1..255)
// PORTS
//  i_clk          in   1   clock, all state updates on rising edge
//  i_rst          in   1   synchronous, active-high reset
//  i_dec_valid    in   1   decode holds a real instruction
//  i_dec_regwrite in   1   decode instruction writes rd
//  i_dec_rd       in   5   decode destination register
//  i_dec_rs1      in   5   decode source register 1
//  i_dec_rs2      in   5   decode source register 2
//  i_dec_opcode   in   7   decode opcode
//  i_stall        in   1   stall request from forwarding unit
//  i_flush        in   1   branch/jump taken in decode: squash instruction entering EX
//  o_hold_front   out  1   hold PC and IF/ID registers (combinational)
//  o_ex_valid     out  1   EX stage valid
//  o_ex_rd        out  5   EX rd (to forwarding unit rd_execute)
//  o_ex_rs1       out  5   EX rs1
//  o_ex_rs2       out  5   EX rs2
//  o_ex_opcode    out  7   EX opcode (to forwarding unit opcode_EX)
//  o_mem_valid    out  1   MEM stage valid
//  o_mem_rd       out  5   MEM rd (to forwarding unit rd_mem)
//  o_mem_opcode   out  7   MEM opcode
//  o_stall_cnt    out  CNT_W  total stall cycles, saturating
//  o_flush_cnt    out  CNT_W  total flush cycles, saturating
//  o_stall_err    out  1   sticky: stall run reached MAX_STALL
// BEHAVIOUR
//  Reset:
//   - All valids 0; all rd/rs fields 0.
//   - Opcodes 7'b0010011 (NOP).
//   - Counters 0, o_stall_err 0, FSM in RUN, run counter 0.
//  Bubble definition: valid 0, rd 0, rs1 0, rs2 0, opcode 7'b0010011.
//  MEM always advances: MEM <= EX every cycle, with one-cycle latency, regardless of stall or flush.
//  EX update, in priority order:
//   - i_flush => bubble.
//   - else i_stall => bubble.
//   - else EX <= decode fields. rd is forced to 0 when !i_dec_valid or !i_dec_regwrite.
//   - valid <= i_dec_valid.
//  o_hold_front = i_stall & ~i_flush. A flush redirects the PC and must never be held.
//  FSM, two states:
//   - RUN: i_stall & ~i_flush -> STALL, run counter <= 1.
//   - STALL: i_stall & ~i_flush -> stay, run counter +1 (saturates at MAX_STALL).
//   - STALL: otherwise -> RUN, run counter <= 0.
//   - When the run counter reaches MAX_STALL, set o_stall_err; it clears only on reset.
//   - Flush has priority: a flush cycle with i_stall high ends the run.
//  Counters:
//   - o_stall_cnt +1 on each cycle with o_hold_front.
//   - o_flush_cnt +1 on each i_flush cycle.
//   - Both hold at all-ones once saturated.
//  Reset mid-stall: EX/MEM become bubbles, FSM returns to RUN, o_hold_front follows i_stall combinationally.
//  X0: writes to rd 0 keep rd 0. A regwrite instruction with rd 0 therefore looks identical to a bubble.
// TESTING
//  1. Reset, then ADD x5 (regwrite, valid) on decode, no stall
//     -> next cycle o_ex_rd=5, o_ex_valid=1; cycle after, o_mem_rd=5, o_ex from the new decode.
//  2. LD x7 in EX, i_stall=1 for one cycle
//     -> o_hold_front=1; next cycle EX=bubble, o_mem_rd=7, o_stall_cnt=1, FSM back to RUN after stall drops.
//  3. i_flush=1 and i_stall=1 together
//     -> o_hold_front=0, EX=bubble, o_flush_cnt+1, o_stall_cnt unchanged, FSM RUN.
//  4. i_stall held 8 cycles (MAX_STALL=8)
//     -> o_stall_err rises on the 8th edge and stays 1 after i_stall drops, until i_rst.
//  5. Decode valid, regwrite=0, rd=9 -> o_ex_rd=0, o_ex_valid=1.
//  6. CNT_W=4, 20 stall cycles (MAX_STALL=255)
//     -> o_stall_cnt stops at 15; reset mid-run clears all outputs on the next edge.

Source files
------------

// File: rtl/id_ex_hazard_pipe.sv
// id_ex_hazard_pipe: decode->execute->memory hazard-metadata pipeline with stall/flush handling,
// saturating event counters and a sticky stall-run watchdog.
module id_ex_hazard_pipe #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dec_valid,
    input  logic             i_dec_regwrite,
    input  logic [4:0]       i_dec_rd,
    input  logic [4:0]       i_dec_rs1,
    input  logic [4:0]       i_dec_rs2,
    input  logic [6:0]       i_dec_opcode,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_hold_front,
    output logic             o_ex_valid,
    output logic [4:0]       o_ex_rd,
    output logic [4:0]       o_ex_rs1,
    output logic [4:0]       o_ex_rs2,
    output logic [6:0]       o_ex_opcode,
    output logic             o_mem_valid,
    output logic [4:0]       o_mem_rd,
    output logic [6:0]       o_mem_opcode,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_stall_err
);
    localparam logic [6:0] NOP = 7'b0010011;
    localparam logic [7:0] MAX = 8'(MAX_STALL);
    typedef enum logic {RUN, STALL} state_t;
    state_t     state, state_nxt;
    logic [7:0] run, run_nxt;
    logic       bubble;
    // a flush redirects the PC, so it always overrides a stall request
    assign o_hold_front = i_stall & ~i_flush;
    assign bubble       = i_flush | i_stall;
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        case (state)
            RUN: begin
                state_nxt = o_hold_front ? STALL : RUN;
                run_nxt   = o_hold_front ? 8'd1 : 8'd0;
            end
            STALL: begin
                state_nxt = o_hold_front ? STALL : RUN;
                run_nxt   = !o_hold_front ? 8'd0 : (run == MAX) ? run : run + 8'd1;
            end
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= RUN;
            run         <= '0;
            o_stall_err <= 1'b0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            o_stall_err <= o_stall_err | (run_nxt == MAX);
            o_stall_cnt <= (o_hold_front && o_stall_cnt != '1) ? o_stall_cnt + 1'b1 : o_stall_cnt;
            o_flush_cnt <= (i_flush && o_flush_cnt != '1) ? o_flush_cnt + 1'b1 : o_flush_cnt;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ex_valid   <= 1'b0;
            o_ex_rd      <= '0;
            o_ex_rs1     <= '0;
            o_ex_rs2     <= '0;
            o_ex_opcode  <= NOP;
            o_mem_valid  <= 1'b0;
            o_mem_rd     <= '0;
            o_mem_opcode <= NOP;
        end else begin
            o_ex_valid   <= bubble ? 1'b0 : i_dec_valid;
            o_ex_rd      <= (bubble || !i_dec_valid || !i_dec_regwrite) ? 5'd0 : i_dec_rd;
            o_ex_rs1     <= bubble ? 5'd0 : i_dec_rs1;
            o_ex_rs2     <= bubble ? 5'd0 : i_dec_rs2;
            o_ex_opcode  <= bubble ? NOP : i_dec_opcode;
            o_mem_valid  <= o_ex_valid;
            o_mem_rd     <= o_ex_rd;
            o_mem_opcode <= o_ex_opcode;
        end
    end
endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// tb_id_ex_hazard_pipe: directed checks of the hazard pipeline, one default instance and one
// with a 4-bit counter and a 255-cycle watchdog sharing the same stimulus.
module tb_id_ex_hazard_pipe;
    localparam logic [6:0] NOP = 7'b0010011;
    logic clk = 1'b0, rst = 1'b1;
    logic dv = 0, dw = 0, st = 0, fl = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [6:0] op = NOP;
    logic hold0, exv0, memv0, err0, hold1, exv1, memv1, err1;
    logic [4:0] exrd0, exrs10, exrs20, memrd0, exrd1, exrs11, exrs21, memrd1;
    logic [6:0] exop0, memop0, exop1, memop1;
    logic [15:0] scnt0, fcnt0;
    logic [3:0] scnt1, fcnt1;
    int vectors = 0, misses = 0;

    always #5 clk = ~clk;

    id_ex_hazard_pipe #(.CNT_W(16), .MAX_STALL(8)) u0 (
        .i_clk(clk), .i_rst(rst), .i_dec_valid(dv), .i_dec_regwrite(dw), .i_dec_rd(rd),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_opcode(op), .i_stall(st), .i_flush(fl),
        .o_hold_front(hold0), .o_ex_valid(exv0), .o_ex_rd(exrd0), .o_ex_rs1(exrs10),
        .o_ex_rs2(exrs20), .o_ex_opcode(exop0), .o_mem_valid(memv0), .o_mem_rd(memrd0),
        .o_mem_opcode(memop0), .o_stall_cnt(scnt0), .o_flush_cnt(fcnt0), .o_stall_err(err0));

    id_ex_hazard_pipe #(.CNT_W(4), .MAX_STALL(255)) u1 (
        .i_clk(clk), .i_rst(rst), .i_dec_valid(dv), .i_dec_regwrite(dw), .i_dec_rd(rd),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_opcode(op), .i_stall(st), .i_flush(fl),
        .o_hold_front(hold1), .o_ex_valid(exv1), .o_ex_rd(exrd1), .o_ex_rs1(exrs11),
        .o_ex_rs2(exrs21), .o_ex_opcode(exop1), .o_mem_valid(memv1), .o_mem_rd(memrd1),
        .o_mem_opcode(memop1), .o_stall_cnt(scnt1), .o_flush_cnt(fcnt1), .o_stall_err(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dec(input logic v, input logic w, input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input logic [6:0] o);
        dv = v; dw = w; rd = d; rs1 = a; rs2 = b; op = o;
    endtask

    initial begin
        tick(2);
        rst = 0;
        chk("rst_ex_valid", exv0, 0);
        chk("rst_ex_rd", exrd0, 0);
        chk("rst_ex_opcode", exop0, NOP);
        chk("rst_mem_valid", memv0, 0);
        chk("rst_mem_opcode", memop0, NOP);
        chk("rst_stall_cnt", scnt0, 0);
        chk("rst_flush_cnt", fcnt0, 0);
        chk("rst_err", err0, 0);
        // ADD x5, x1, x2
        dec(1, 1, 5, 1, 2, 7'h33);
        tick();
        chk("add_ex_rd", exrd0, 5);
        chk("add_ex_valid", exv0, 1);
        chk("add_ex_rs1", exrs10, 1);
        chk("add_ex_rs2", exrs20, 2);
        chk("add_ex_opcode", exop0, 7'h33);
        // LD x7, (x3)
        dec(1, 1, 7, 3, 0, 7'h03);
        tick();
        chk("add_mem_rd", memrd0, 5);
        chk("add_mem_valid", memv0, 1);
        chk("ld_ex_rd", exrd0, 7);
        chk("ld_ex_opcode", exop0, 7'h03);
        // load-use stall for one cycle
        dec(1, 1, 8, 7, 4, 7'h33);
        st = 1;
        #1;
        chk("stall_hold", hold0, 1);
        tick();
        chk("stall_ex_valid", exv0, 0);
        chk("stall_ex_rd", exrd0, 0);
        chk("stall_ex_rs1", exrs10, 0);
        chk("stall_ex_opcode", exop0, NOP);
        chk("stall_mem_rd", memrd0, 7);
        chk("stall_mem_opcode", memop0, 7'h03);
        chk("stall_cnt1", scnt0, 1);
        st = 0;
        #1;
        chk("unstall_hold", hold0, 0);
        tick();
        chk("resume_ex_rd", exrd0, 8);
        chk("resume_mem_valid", memv0, 0);
        chk("resume_mem_opcode", memop0, NOP);
        // flush together with stall
        st = 1; fl = 1;
        #1;
        chk("flush_hold", hold0, 0);
        tick();
        chk("flush_ex_valid", exv0, 0);
        chk("flush_ex_opcode", exop0, NOP);
        chk("flush_cnt1", fcnt0, 1);
        chk("flush_stall_cnt", scnt0, 1);
        chk("flush_mem_rd", memrd0, 8);
        // a flush inside a stall run restarts the watchdog run
        fl = 0;
        tick(7);
        fl = 1;
        tick();
        fl = 0;
        tick(7);
        chk("split_run_err", err0, 0);
        chk("split_stall_cnt", scnt0, 15);
        chk("split_flush_cnt", fcnt0, 2);
        st = 0;
        tick();
        chk("split_after_err", err0, 0);
        // watchdog: 8 consecutive stall cycles
        st = 1;
        tick(7);
        chk("wd_7_err", err0, 0);
        tick();
        chk("wd_8_err", err0, 1);
        chk("wd_stall_cnt", scnt0, 23);
        st = 0;
        tick(3);
        chk("wd_sticky", err0, 1);
        rst = 1;
        tick();
        chk("wd_rst_err", err0, 0);
        chk("wd_rst_cnt", scnt0, 0);
        chk("wd_rst_fcnt", fcnt0, 0);
        rst = 0;
        // rd gated by regwrite / valid, and x0 writes
        dec(1, 0, 9, 1, 1, 7'h63);
        tick();
        chk("nowr_ex_rd", exrd0, 0);
        chk("nowr_ex_valid", exv0, 1);
        dec(0, 1, 4, 1, 1, 7'h33);
        tick();
        chk("inval_ex_rd", exrd0, 0);
        chk("inval_ex_valid", exv0, 0);
        dec(1, 1, 0, 2, 3, 7'h33);
        tick();
        chk("x0_ex_rd", exrd0, 0);
        chk("x0_ex_valid", exv0, 1);
        // 4-bit counter saturation over a 20-cycle stall
        dec(0, 0, 0, 0, 0, NOP);
        st = 1;
        tick(20);
        chk("sat_cnt1", scnt1, 15);
        chk("sat_err1", err1, 0);
        chk("sat_cnt0", scnt0, 20);
        chk("sat_err0", err0, 1);
        // reset in the middle of the stall run
        dec(1, 1, 6, 1, 2, 7'h33);
        rst = 1;
        tick();
        chk("mid_rst_cnt1", scnt1, 0);
        chk("mid_rst_err0", err0, 0);
        chk("mid_rst_ex_valid", exv0, 0);
        chk("mid_rst_ex_rd", exrd0, 0);
        chk("mid_rst_mem_valid", memv0, 0);
        chk("mid_rst_hold", hold0, 1);
        rst = 0;
        tick();
        chk("post_rst_cnt1", scnt1, 1);
        tick(6);
        chk("post_rst_7_err", err0, 0);
        tick();
        chk("post_rst_8_err", err0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
